// File: rtl/frac_clken_gen_pkg.sv
// frac_clken_gen_pkg: shared defaults, settle-counter width and per-channel config record
package frac_clken_gen_pkg;
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_ACC_W = 32;
  localparam int DEF_SETTLE_CYCLES = 16;
  localparam int CNT_W = 8;
  localparam int ACC_MAX = 32;
  typedef struct packed {
    logic [ACC_MAX-1:0] inc;
    logic [ACC_MAX-1:0] phase;
  } ch_cfg_t;
endpackage

// File: rtl/frac_clken_gen_ch.sv
// frac_clken_ch: one phase accumulator whose carry-out is the registered clock enable
module frac_clken_ch #(
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             apply,
  input  logic [ACC_W-1:0] inc_ld,
  input  logic [ACC_W-1:0] phase_ld,
  output logic             ce
);
  logic [ACC_W-1:0] inc_q, inc_d, acc_q, acc_d;
  logic             ce_q, ce_d;
  logic [ACC_W:0]   sum;
  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, inc_q};
    inc_d = apply ? inc_ld : inc_q;
    acc_d = apply ? phase_ld : sum[ACC_W-1:0];
    ce_d  = apply ? 1'b0 : sum[ACC_W];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inc_q <= '0;
      acc_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      inc_q <= inc_d;
      acc_q <= acc_d;
      ce_q  <= ce_d;
    end
  end
  assign ce = ce_q;
endmodule

// File: rtl/frac_clken_gen.sv
// frac_clken_gen: multi-channel fractional clock-enable generator with shadowed config and lock tracking
module frac_clken_gen
  import frac_clken_gen_pkg::*;
#(
  parameter int NUM_CH        = DEF_NUM_CH,
  parameter int ACC_W         = DEF_ACC_W,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_wr,
  input  logic [3:0]        cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic [ACC_W-1:0]  cfg_phase,
  input  logic              cfg_apply,
  output logic [NUM_CH-1:0] ce,
  output logic              locked
);
  localparam logic [CNT_W-1:0] SETTLE = CNT_W'(SETTLE_CYCLES);
  ch_cfg_t          sh_q [NUM_CH];
  ch_cfg_t          sh_d [NUM_CH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d, locked_q, locked_d;
  always_comb begin
    for (int i = 0; i < NUM_CH; i++)
      sh_d[i] = (cfg_wr && cfg_ch == 4'(i)) ? ch_cfg_t'{inc: ACC_MAX'(cfg_inc), phase: ACC_MAX'(cfg_phase)} : sh_q[i];
    run_d    = run_q | cfg_apply;
    cnt_d    = cfg_apply ? '0 : (run_q && cnt_q != SETTLE) ? cnt_q + CNT_W'(1) : cnt_q;
    locked_d = run_d && cnt_d == SETTLE;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) sh_q[i] <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) sh_q[i] <= sh_d[i];
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      locked_q <= locked_d;
    end
  end
  // apply always loads the pre-edge shadow contents, so a same-edge write waits for the next apply
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    frac_clken_ch #(.ACC_W(ACC_W)) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .apply    (cfg_apply),
      .inc_ld   (ACC_W'(sh_q[c].inc)),
      .phase_ld (ACC_W'(sh_q[c].phase)),
      .ce       (ce[c])
    );
  end
  assign locked = locked_q;
endmodule

// File: doc/frac_clken_gen.md
FRAC_CLKEN_GEN -- requirements
Module: frac_clken_gen

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, meaning the number of clock-enable channels (1..16).
REQ-002 The block SHALL have parameter ACC_W, default 32, meaning the phase-accumulator width in bits (8..32).
REQ-003 The block SHALL have parameter SETTLE_CYCLES, default 16, meaning the cycles from apply to locked (1..255).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port cfg_wr, input, 1 bit: one-cycle shadow-register write strobe.
REQ-007 The block SHALL have port cfg_ch, input, 4 bits: channel index for the write.
REQ-008 The block SHALL have port cfg_inc, input, ACC_W bits: frequency increment (f_ce = f_clk * inc / 2^ACC_W).
REQ-009 The block SHALL have port cfg_phase, input, ACC_W bits: start value of the accumulator, which sets the phase offset.
REQ-010 The block SHALL have port cfg_apply, input, 1 bit: one-cycle strobe that restarts all channels from the shadow registers.
REQ-011 The block SHALL have port ce, output, NUM_CH bits: registered per-channel clock-enable pulses.
REQ-012 The block SHALL have port locked, output, 1 bit: high when all channels are running from a settled configuration.

Function
REQ-013 Each channel i SHALL hold the shadow registers inc_sh[i] and phase_sh[i], plus the active registers inc_act[i] and acc[i].
REQ-014 On an edge with cfg_wr=1 and cfg_ch<NUM_CH, the block SHALL set inc_sh[cfg_ch]<=cfg_inc and phase_sh[cfg_ch]<=cfg_phase; writes with cfg_ch>=NUM_CH SHALL be ignored.
REQ-015 On an edge with cfg_apply=1, for every channel the block SHALL set inc_act<=inc_sh, acc<=phase_sh and ce<=0, and SHALL clear the settle counter and drive locked<=0.
REQ-016 On an edge with cfg_apply=1 and cfg_wr=1 together, apply SHALL use the shadow values from before that edge; the write SHALL land in the shadow registers for the next apply.
REQ-017 On every other edge, each channel SHALL compute sum = acc + inc_act as an (ACC_W+1)-bit value, set acc<=sum[ACC_W-1:0], and set ce[i]<=sum[ACC_W] (carry-out).
REQ-018 The first ce pulse of a channel SHALL occur on the first edge at which phase_sh + k*inc_act >= 2^ACC_W, where k counts edges after apply.
REQ-019 A channel with inc_act=0 SHALL hold ce[i]=0 permanently, and its acc SHALL remain at its phase value.
REQ-020 A channel with inc_act=2^ACC_W-1 SHALL pulse ce on all but one of every 2^ACC_W cycles (wrap-around without saturation).
REQ-021 Each ce pulse SHALL be exactly one clk cycle wide; ce SHALL never be high for two cycles in a row unless inc_act >= 2^(ACC_W-1).
REQ-022 Channels applied together SHALL keep a fixed relative phase: equal inc_act with phase difference d SHALL give a constant pulse offset of d/inc_act cycles.
REQ-023 Settle counter: 8 bits; it SHALL increment every edge after an apply, saturating at SETTLE_CYCLES; locked SHALL go to 1 on the edge at which the counter reaches SETTLE_CYCLES.
REQ-024 Before the first apply after reset, the settle counter SHALL stay at 0 and locked SHALL remain 0.
REQ-025 A new cfg_apply while locked=1 or while settling SHALL restart the settle sequence (locked low for SETTLE_CYCLES cycles).
REQ-026 Shadow writes without an apply SHALL have no effect on ce, acc or locked.

Reset
REQ-027 While reset_n=0, all shadow registers, active registers and accumulators SHALL be 0, ce SHALL be 0, locked SHALL be 0, and the settle counter SHALL be 0.
REQ-028 Reset assertion mid-operation SHALL clear all state immediately (asynchronously), including any pending settle.
REQ-029 Deassertion of reset_n SHALL be taken synchronous to clk by the integrator; after release, the block SHALL be idle (all ce=0) until an apply.

Structure
REQ-030 A shared package SHALL hold the default parameter values, the settle-counter width constant (8), and the per-channel config record type (inc, phase).
REQ-031 The per-channel accumulator and carry register SHALL be the sub-module frac_clken_ch, instantiated NUM_CH times by a generate loop.
REQ-032 The top level SHALL hold the shadow registers, the apply broadcast, the settle counter and locked.

Verification
REQ-033 Bench (ACC_W=8): ch0 inc=64 phase=0, apply -> ce[0] pulses on edges 4, 8, 12... after apply; locked rises 16 edges after apply.
REQ-034 Bench (ACC_W=8): ch0 and ch1 both inc=64, ch1 phase=128, apply -> ce[1] leads ce[0] by exactly 2 cycles, constant over 1000 cycles.
REQ-035 Bench (ACC_W=8): ch2 inc=0; ch3 inc=255 -> ce[2] never asserts; ce[3] is low on exactly 1 of every 256 cycles.
REQ-036 Bench: cfg_wr (ch0 inc=32) on the same edge as cfg_apply -> old inc in use; after a second apply the ce[0] period is 8 cycles; cfg_ch=9 write leaves all shadows unchanged.
REQ-037 Bench: reset_n pulled low while locked=1, at mid-pulse -> ce=0 and locked=0 immediately; no ce pulses after release until a new apply.
